instr_cache: RTL and testbench



---
 rtl/icache_pkg.sv | 32 +++
 rtl/instr_cache_if.sv | 17 +
 rtl/icache_array.sv | 74 +++++++
 rtl/instr_cache.sv | 169 ++++++++++++++++
 tb/tb_instr_cache.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg: shared types and helpers for the instruction cache.
//   - icache_state_e : controller state encoding (IDLE / REFILL / GAP)
//   - ICACHE_IDX_W   : default index width (2^IDX_W halfword entries)
//   - is_compressed  : RV32C halfword detection on the low two bits
//   - addr_idx/addr_tag : halfword index and tag extraction for a byte address
// -----------------------------------------------------------------------------
package icache_pkg;

    localparam int ICACHE_IDX_W = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        GAP    = 2'd2
    } icache_state_e;

    function automatic logic is_compressed(input logic [15:0] hw);
        return (hw[1:0] != 2'b11);
    endfunction

    // Halfword index = addr[idx_w:1]; caller truncates to idx_w bits.
    function automatic logic [31:0] addr_idx(input logic [31:0] a, input int idx_w);
        return (a >> 1) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    // Tag = addr[31:idx_w+1]; caller truncates to 31-idx_w bits.
    function automatic logic [31:0] addr_tag(input logic [31:0] a, input int idx_w);
        return a >> (idx_w + 1);
    endfunction

endpackage

// File: rtl/instr_cache_if.sv
// -----------------------------------------------------------------------------
// instr_cache_if: memory-controller refill port of the instruction cache.
//   mc_req  : refill request, held until mc_done       (cache -> controller)
//   mc_addr : refill byte address                      (cache -> controller)
//   mc_done : refill complete, one-cycle pulse         (controller -> cache)
//   mc_data : bytes addr..addr+3, little-endian        (controller -> cache)
// master = cache side, slave = memory-controller side.
// -----------------------------------------------------------------------------
interface instr_cache_if;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic        mc_done;
    logic [31:0] mc_data;

    modport master (output mc_req, output mc_addr, input mc_done, input mc_data);
    modport slave  (input mc_req, input mc_addr, output mc_done, output mc_data);
endinterface

// File: rtl/icache_array.sv
// -----------------------------------------------------------------------------
// icache_array: direct-mapped halfword storage (valid/tag/data per entry).
// Ports:
//   clk, rst               : clock, synchronous active-high reset (valid only)
//   i_rd0_addr/o_rd0_hit/o_rd0_data : combinational read port 0 (byte address)
//   i_rd1_addr/o_rd1_hit/o_rd1_data : combinational read port 1 (byte address)
//   i_we0/i_wa0/i_wd0      : synchronous write port 0
//   i_we1/i_wa1/i_wd1      : synchronous write port 1
// The two write ports never target the same index in one edge (they always
// carry consecutive halfword addresses).
// -----------------------------------------------------------------------------
module icache_array
    import icache_pkg::*;
#(
    parameter int IDX_W = ICACHE_IDX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_rd0_addr,
    output logic        o_rd0_hit,
    output logic [15:0] o_rd0_data,
    input  logic [31:0] i_rd1_addr,
    output logic        o_rd1_hit,
    output logic [15:0] o_rd1_data,
    input  logic        i_we0,
    input  logic [31:0] i_wa0,
    input  logic [15:0] i_wd0,
    input  logic        i_we1,
    input  logic [31:0] i_wa1,
    input  logic [15:0] i_wd1
);
    localparam int N     = 1 << IDX_W;
    localparam int TAG_W = 31 - IDX_W;

    logic [N-1:0]     r_valid;
    logic [TAG_W-1:0] r_tag  [N];
    logic [15:0]      r_data [N];

    logic [IDX_W-1:0] w_ri0, w_ri1, w_wi0, w_wi1;
    logic [TAG_W-1:0] w_rt0, w_rt1, w_wt0, w_wt1;

    assign w_ri0 = IDX_W'(addr_idx(i_rd0_addr, IDX_W));
    assign w_ri1 = IDX_W'(addr_idx(i_rd1_addr, IDX_W));
    assign w_wi0 = IDX_W'(addr_idx(i_wa0, IDX_W));
    assign w_wi1 = IDX_W'(addr_idx(i_wa1, IDX_W));
    assign w_rt0 = TAG_W'(addr_tag(i_rd0_addr, IDX_W));
    assign w_rt1 = TAG_W'(addr_tag(i_rd1_addr, IDX_W));
    assign w_wt0 = TAG_W'(addr_tag(i_wa0, IDX_W));
    assign w_wt1 = TAG_W'(addr_tag(i_wa1, IDX_W));

    assign o_rd0_hit  = r_valid[w_ri0] && (r_tag[w_ri0] == w_rt0);
    assign o_rd0_data = r_data[w_ri0];
    assign o_rd1_hit  = r_valid[w_ri1] && (r_tag[w_ri1] == w_rt1);
    assign o_rd1_data = r_data[w_ri1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            // Eviction is unconditional: a write always replaces the tag.
            if (i_we0) begin
                r_valid[w_wi0] <= 1'b1;
                r_tag[w_wi0]   <= w_wt0;
                r_data[w_wi0]  <= i_wd0;
            end
            if (i_we1) begin
                r_valid[w_wi1] <= 1'b1;
                r_tag[w_wi1]   <= w_wt1;
                r_data[w_wi1]  <= i_wd1;
            end
        end
    end

endmodule

// File: rtl/instr_cache.sv
// -----------------------------------------------------------------------------
// instr_cache: direct-mapped, halfword-granular instruction cache in front of
// the fetch stage. Returns one 32-bit or one zero-extended 16-bit instruction
// per request as a one-cycle instr_ready pulse; misses refill 4 bytes through
// the memory-controller port.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   rdy           : global ready; low freezes all state
//   rob_clear     : pipeline flush
//   start_fetch   : fetch request (level), pc = halfword-aligned address
//   instr_ready   : one-cycle result pulse; instr / instr_addr hold afterwards
//   mc            : memory-controller refill port (instr_cache_if.master)
//   hit_cnt/miss_cnt : statistics counters, present only with ICACHE_STAT_EN
// Optional feature macro: ICACHE_STAT_EN
// -----------------------------------------------------------------------------
module instr_cache
    import icache_pkg::*;
#(
    parameter int IDX_W = ICACHE_IDX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               rob_clear,
    input  logic               start_fetch,
    input  logic [31:0]        pc,
    output logic               instr_ready,
    output logic [31:0]        instr,
    output logic [31:0]        instr_addr,
`ifdef ICACHE_STAT_EN
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt,
`endif
    instr_cache_if.master      mc
);
    icache_state_e r_state, w_state_n;
    logic        r_instr_ready, w_instr_ready_n;
    logic [31:0] r_instr, w_instr_n;
    logic [31:0] r_instr_addr, w_instr_addr_n;
    logic        r_mc_req, w_mc_req_n;
    logic [31:0] r_mc_addr, w_mc_addr_n;
    // Set when a flush lands during REFILL; the refill completes but its
    // pulse is dropped.
    logic        r_kill, w_kill_n;

    logic        w_fill, w_hit_ev, w_miss_ev;
    logic        w_lo_hit, w_hi_hit, w_lo_cmp, w_hit;
    logic [15:0] w_lo_data, w_hi_data;
    logic [31:0] w_hi_addr, w_hit_instr, w_fill_instr;

    assign w_hi_addr = pc + 32'd2;  // wraps mod 2^32

    icache_array #(.IDX_W(IDX_W)) u_array (
        .clk        (clk),
        .rst        (rst),
        .i_rd0_addr (pc),
        .o_rd0_hit  (w_lo_hit),
        .o_rd0_data (w_lo_data),
        .i_rd1_addr (w_hi_addr),
        .o_rd1_hit  (w_hi_hit),
        .o_rd1_data (w_hi_data),
        .i_we0      (w_fill & rdy),
        .i_wa0      (r_mc_addr),
        .i_wd0      (mc.mc_data[15:0]),
        .i_we1      (w_fill & rdy),
        .i_wa1      (r_mc_addr + 32'd2),
        .i_wd1      (mc.mc_data[31:16])
    );

    // A compressed instruction only needs the low halfword.
    assign w_lo_cmp     = is_compressed(w_lo_data);
    assign w_hit        = w_lo_hit && (w_lo_cmp || w_hi_hit);
    assign w_hit_instr  = w_lo_cmp ? {16'b0, w_lo_data} : {w_hi_data, w_lo_data};
    assign w_fill_instr = is_compressed(mc.mc_data[15:0]) ? {16'b0, mc.mc_data[15:0]}
                                                          : mc.mc_data;

    always_comb begin
        w_state_n       = r_state;
        w_instr_ready_n = 1'b0;
        w_instr_n       = r_instr;
        w_instr_addr_n  = r_instr_addr;
        w_mc_req_n      = r_mc_req;
        w_mc_addr_n     = r_mc_addr;
        w_kill_n        = r_kill;
        w_fill          = 1'b0;
        w_hit_ev        = 1'b0;
        w_miss_ev       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_fetch && !rob_clear) begin
                    if (w_hit) begin
                        w_instr_ready_n = 1'b1;
                        w_instr_n       = w_hit_instr;
                        w_instr_addr_n  = pc;
                        w_state_n       = GAP;
                        w_hit_ev        = 1'b1;
                    end else begin
                        w_mc_req_n  = 1'b1;
                        w_mc_addr_n = {pc[31:1], 1'b0};
                        w_kill_n    = 1'b0;
                        w_state_n   = REFILL;
                        w_miss_ev   = 1'b1;
                    end
                end
            end
            REFILL: begin
                if (rob_clear) w_kill_n = 1'b1;
                if (mc.mc_done) begin
                    w_fill     = 1'b1;
                    w_mc_req_n = 1'b0;
                    w_kill_n   = 1'b0;
                    if (rob_clear || r_kill) begin
                        w_state_n = IDLE;
                    end else begin
                        w_instr_ready_n = 1'b1;
                        w_instr_n       = w_fill_instr;
                        w_instr_addr_n  = r_mc_addr;
                        w_state_n       = GAP;
                    end
                end
            end
            // One dead cycle absorbs the fetcher's late drop of start_fetch.
            GAP:     w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_instr_ready <= 1'b0;
            r_instr       <= '0;
            r_instr_addr  <= '0;
            r_mc_req      <= 1'b0;
            r_mc_addr     <= '0;
            r_kill        <= 1'b0;
        end else if (rdy) begin
            r_state       <= w_state_n;
            r_instr_ready <= w_instr_ready_n;
            r_instr       <= w_instr_n;
            r_instr_addr  <= w_instr_addr_n;
            r_mc_req      <= w_mc_req_n;
            r_mc_addr     <= w_mc_addr_n;
            r_kill        <= w_kill_n;
        end
    end

    assign instr_ready = r_instr_ready;
    assign instr       = r_instr;
    assign instr_addr  = r_instr_addr;
    assign mc.mc_req   = r_mc_req;
    assign mc.mc_addr  = r_mc_addr;

`ifdef ICACHE_STAT_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (rdy) begin
            if (w_hit_ev)  r_hit_cnt  <= r_hit_cnt + 32'd1;
            if (w_miss_ev) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end
    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_instr_cache.sv
module tb_instr_cache;
    logic        clk = 1'b0;
    logic        rst, rdy, rob_clear, start_fetch;
    logic [31:0] pc;
    logic        instr_ready;
    logic [31:0] instr, instr_addr;
`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif
    instr_cache_if mc_bus ();

    logic [7:0] mem [0:255];
    int n_checks = 0;
    int n_fail   = 0;

    instr_cache dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .rob_clear   (rob_clear),
        .start_fetch (start_fetch),
        .pc          (pc),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_addr  (instr_addr),
`ifdef ICACHE_STAT_EN
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt),
`endif
        .mc          (mc_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] memw(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
    endfunction

    // Issue a fetch at a, expect hit (1-cycle pulse) or a refill at a,
    // then check the GAP cycle ignores the still-asserted start_fetch.
    task automatic fetch(input logic [31:0] a, input logic exp_hit,
                         input logic [31:0] exp_instr, input string name);
        @(negedge clk);
        start_fetch = 1'b1;
        pc = a;
        @(negedge clk);
        if (exp_hit) begin
            chk({name, "_hit_ready"}, {31'b0, instr_ready}, 32'd1);
            chk({name, "_hit_noreq"}, {31'b0, mc_bus.mc_req}, 32'd0);
        end else begin
            chk({name, "_miss_noready"}, {31'b0, instr_ready}, 32'd0);
            chk({name, "_miss_req"}, {31'b0, mc_bus.mc_req}, 32'd1);
            chk({name, "_miss_addr"}, mc_bus.mc_addr, a);
            repeat (2) @(negedge clk);
            chk({name, "_req_held"}, {31'b0, mc_bus.mc_req}, 32'd1);
            mc_bus.mc_data = memw(a);
            mc_bus.mc_done = 1'b1;
            @(negedge clk);
            mc_bus.mc_done = 1'b0;
            chk({name, "_fill_ready"}, {31'b0, instr_ready}, 32'd1);
        end
        chk({name, "_instr"}, instr, exp_instr);
        chk({name, "_iaddr"}, instr_addr, a);
        @(negedge clk);
        chk({name, "_gap_noready"}, {31'b0, instr_ready}, 32'd0);
        chk({name, "_gap_noreq"}, {31'b0, mc_bus.mc_req}, 32'd0);
        start_fetch = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        // pc 0: addi x1,x0,5
        mem[8'h00] = 8'h93; mem[8'h01] = 8'h00; mem[8'h02] = 8'h50; mem[8'h03] = 8'h00;
        // pc 4: c.li a0,1 (compressed)
        mem[8'h04] = 8'h05; mem[8'h05] = 8'h45;
        // pc 0x20: c.nop; pc 0x22: addi a0,x0,1 split across 0x22/0x24
        mem[8'h20] = 8'h01; mem[8'h21] = 8'h00; mem[8'h22] = 8'h13; mem[8'h23] = 8'h05;
        mem[8'h24] = 8'h10; mem[8'h25] = 8'h00;
        // pc 0x40: add x1,x2,x3
        mem[8'h40] = 8'hb3; mem[8'h41] = 8'h00; mem[8'h42] = 8'h31; mem[8'h43] = 8'h00;
        // pc 0x60: jal x0,0
        mem[8'h60] = 8'h6f;
        // pc 0x7E: 32-bit straddling the index wrap into 0x80
        mem[8'h7e] = 8'h37; mem[8'h7f] = 8'h05;
        // pc 0x80: same index as pc 0
        mem[8'h80] = 8'h13; mem[8'h81] = 8'h01; mem[8'h82] = 8'h00; mem[8'h83] = 8'h01;

        rst = 1'b1; rdy = 1'b1; rob_clear = 1'b0; start_fetch = 1'b0; pc = '0;
        mc_bus.mc_done = 1'b0; mc_bus.mc_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, instr_ready}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_iaddr", instr_addr, 32'd0);
        chk("rst_req", {31'b0, mc_bus.mc_req}, 32'd0);
        chk("rst_mcaddr", mc_bus.mc_addr, 32'd0);
        rst = 1'b0;

        fetch(32'h0, 1'b0, 32'h0050_0093, "cold");
        fetch(32'h0, 1'b1, 32'h0050_0093, "hit0");

        // rdy low freezes a pending hit
        @(negedge clk);
        rdy = 1'b0; start_fetch = 1'b1; pc = 32'h0;
        @(negedge clk);
        chk("frz_ready1", {31'b0, instr_ready}, 32'd0);
        @(negedge clk);
        chk("frz_ready2", {31'b0, instr_ready}, 32'd0);
        rdy = 1'b1;
        @(negedge clk);
        chk("frz_release", {31'b0, instr_ready}, 32'd1);
        @(negedge clk);
        start_fetch = 1'b0;

        fetch(32'h4, 1'b0, 32'h0000_4505, "cmp_miss");
        fetch(32'h4, 1'b1, 32'h0000_4505, "cmp_hit");

        fetch(32'h20, 1'b0, 32'h0000_0001, "nop20");
        fetch(32'h22, 1'b0, 32'h0010_0513, "split_miss");
        fetch(32'h22, 1'b1, 32'h0010_0513, "split_hit");

        fetch(32'h80, 1'b0, 32'h0100_0113, "conf80a");
        fetch(32'h0,  1'b0, 32'h0050_0093, "conf0");
        fetch(32'h80, 1'b0, 32'h0100_0113, "conf80b");

        // Flush during refill: request held, data kept, no pulse
        @(negedge clk);
        start_fetch = 1'b1; pc = 32'h40;
        @(negedge clk);
        chk("fl_req", {31'b0, mc_bus.mc_req}, 32'd1);
        rob_clear = 1'b1; start_fetch = 1'b0;
        @(negedge clk);
        rob_clear = 1'b0;
        chk("fl_req_held", {31'b0, mc_bus.mc_req}, 32'd1);
        mc_bus.mc_data = memw(32'h40);
        mc_bus.mc_done = 1'b1;
        @(negedge clk);
        mc_bus.mc_done = 1'b0;
        chk("fl_noready", {31'b0, instr_ready}, 32'd0);
        chk("fl_req_drop", {31'b0, mc_bus.mc_req}, 32'd0);
        fetch(32'h40, 1'b1, 32'h0031_00b3, "fl_after");

        // Flush coinciding with mc_done
        @(negedge clk);
        start_fetch = 1'b1; pc = 32'h60;
        @(negedge clk);
        chk("fd_req", {31'b0, mc_bus.mc_req}, 32'd1);
        start_fetch = 1'b0;
        mc_bus.mc_data = memw(32'h60);
        mc_bus.mc_done = 1'b1; rob_clear = 1'b1;
        @(negedge clk);
        mc_bus.mc_done = 1'b0; rob_clear = 1'b0;
        chk("fd_noready", {31'b0, instr_ready}, 32'd0);
        chk("fd_req_drop", {31'b0, mc_bus.mc_req}, 32'd0);
        fetch(32'h60, 1'b1, 32'h0000_006f, "fd_after");

        // Index wrap: halves at idx 63 and idx 0 carry their own tags
        fetch(32'h7e, 1'b0, 32'h0113_0537, "wrap_miss");
        fetch(32'h7e, 1'b1, 32'h0113_0537, "wrap_hit");
        fetch(32'h80, 1'b1, 32'h0100_0113, "wrap_80hit");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
